// File: rtl/rst_sequencer_if.sv
// Control-path bundle between the board reset sequencer and its environment:
// MMCM lock and software request in, system reset and status out.
interface rst_sequencer_if;
    logic       mmcm_locked;
    logic       sw_rst_req;
    logic       lock_lost_clr;
    logic       sys_rst_n;
    logic [2:0] seq_state;
    logic       lock_lost;
    logic [7:0] rst_count;

    modport master (
        output mmcm_locked,
        output sw_rst_req,
        output lock_lost_clr,
        input  sys_rst_n,
        input  seq_state,
        input  lock_lost,
        input  rst_count
    );

    modport slave (
        input  mmcm_locked,
        input  sw_rst_req,
        input  lock_lost_clr,
        output sys_rst_n,
        output seq_state,
        output lock_lost,
        output rst_count
    );
endinterface

// File: rtl/rst_sequencer.sv
// Board reset sequencer: qualifies MMCM lock, holds reset, re-issues on lock loss / sw request.
// Latency: release 3+LOCK_STABLE+HOLD_CYCLES edges after lock; 3-edge assertion on lock loss; no backpressure.
module rst_sequencer #(
    parameter int LOCK_STABLE = 1000,
    parameter int HOLD_CYCLES = 64,
    parameter int SW_PULSE    = 32,
    parameter int CNT_W       = 16
) (
    input  logic          clk10,
    input  logic          asyncrst_n,
    rst_sequencer_if.slave ctl
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        SW_RST    = 3'd4
    } seq_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(SW_PULSE - 1);

    logic             lock_meta;
    logic             locked_s;
    logic             sw_meta;
    logic             sw_s;
    logic             sw_d;
    logic             sw_rise;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lost_set;
    logic             count_inc;

    logic             sys_rst_reg;
    logic             lock_lost_reg;
    logic [7:0]       rst_count_reg;

    // Both asynchronous inputs get a plain 2-FF synchronizer; the request also
    // gets a delay flop so a held level yields a single rising-edge event.
    always_ff @(posedge clk10 or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
            sw_meta   <= 1'b0;
            sw_s      <= 1'b0;
            sw_d      <= 1'b0;
        end else begin
            lock_meta <= ctl.mmcm_locked;
            locked_s  <= lock_meta;
            sw_meta   <= ctl.sw_rst_req;
            sw_s      <= sw_meta;
            sw_d      <= sw_s;
        end
    end

    assign sw_rise = sw_s & ~sw_d;

    always_ff @(posedge clk10 or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            sys_rst_reg <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sys_rst_reg <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        lost_set  = 1'b0;
        count_inc = 1'b0;

        case (state)
            WAIT_LOCK: begin
                if (locked_s)
                    state_nxt = STABLE;
            end
            STABLE: begin
                if (!locked_s)
                    state_nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST)
                    state_nxt = HOLD;
                else
                    cnt_nxt = cnt + CNT_ONE;
            end
            HOLD: begin
                if (!locked_s)
                    state_nxt = WAIT_LOCK;
                else if (cnt == HOLD_LAST)
                    state_nxt = RUN;
                else
                    cnt_nxt = cnt + CNT_ONE;
            end
            RUN: begin
                // Lock loss outranks a simultaneous software request.
                if (!locked_s)
                    state_nxt = WAIT_LOCK;
                else if (sw_rise)
                    state_nxt = SW_RST;
            end
            SW_RST: begin
                if (!locked_s)
                    state_nxt = WAIT_LOCK;
                else if (cnt == PULSE_LAST)
                    state_nxt = HOLD;
                else
                    cnt_nxt = cnt + CNT_ONE;
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase

        lost_set  = (state_nxt == WAIT_LOCK) &&
                    ((state == HOLD) || (state == RUN) || (state == SW_RST));
        count_inc = (state == RUN) &&
                    ((state_nxt == WAIT_LOCK) || (state_nxt == SW_RST));
    end

    // A new loss event wins over a coincident clear so it is never dropped.
    always_ff @(posedge clk10 or negedge asyncrst_n) begin
        if (!asyncrst_n)
            lock_lost_reg <= 1'b0;
        else if (lost_set)
            lock_lost_reg <= 1'b1;
        else if (ctl.lock_lost_clr)
            lock_lost_reg <= 1'b0;
    end

    always_ff @(posedge clk10 or negedge asyncrst_n) begin
        if (!asyncrst_n)
            rst_count_reg <= 8'd0;
        else if (count_inc && (rst_count_reg != 8'hFF))
            rst_count_reg <= rst_count_reg + 8'd1;
    end

    assign ctl.sys_rst_n = sys_rst_reg;
    assign ctl.seq_state = state;
    assign ctl.lock_lost = lock_lost_reg;
    assign ctl.rst_count = rst_count_reg;

    a_rst_only_in_run: assert property (@(posedge clk10) disable iff (!asyncrst_n)
        sys_rst_reg |-> (state == RUN));

    a_legal_state: assert property (@(posedge clk10) disable iff (!asyncrst_n)
        (state <= SW_RST));

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with L=8, H=4, S=2: expected sys_rst_n edges
// and status snapshots are queued by the stimulus and checked by independent monitors.
module tb_rst_sequencer;
    localparam int L = 8;
    localparam int H = 4;
    localparam int S = 2;

    logic clk10 = 1'b0;
    logic asyncrst_n;

    rst_sequencer_if rif ();

    rst_sequencer #(
        .LOCK_STABLE(L),
        .HOLD_CYCLES(H),
        .SW_PULSE   (S),
        .CNT_W      (16)
    ) dut (
        .clk10     (clk10),
        .asyncrst_n(asyncrst_n),
        .ctl       (rif)
    );

    always #5 clk10 = ~clk10;

    int cyc = 0;
    always @(posedge clk10) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    st;
        int    rst;
        int    ll;
        int    rc;
        string name;
    } snap_t;

    typedef struct {
        int cyc;
        int val;
    } edge_t;

    snap_t snap_q[$];
    snap_t async_q[$];
    edge_t edge_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic void exp_snap(int c, int st, int r, int ll, int rc, string n);
        snap_t s;
        int    i;
        s.cyc = c; s.st = st; s.rst = r; s.ll = ll; s.rc = rc; s.name = n;
        i = 0;
        while (i < snap_q.size() && snap_q[i].cyc <= c) i++;
        snap_q.insert(i, s);
    endfunction

    function automatic void exp_edge(int c, int v);
        edge_t e;
        int    i;
        e.cyc = c; e.val = v;
        i = 0;
        while (i < edge_q.size() && edge_q[i].cyc <= c) i++;
        edge_q.insert(i, e);
    endfunction

    function automatic void check_snap(snap_t s);
        int st_a, rst_a, ll_a, rc_a;
        st_a  = int'(rif.seq_state);
        rst_a = int'(rif.sys_rst_n);
        ll_a  = int'(rif.lock_lost);
        rc_a  = int'(rif.rst_count);
        total++;
        if (st_a != s.st || rst_a != s.rst || ll_a != s.ll || rc_a != s.rc) begin
            bad++;
            $display("FAIL %s cyc=%0d: got st=%0d rst_n=%0d lost=%0d cnt=%0d, want st=%0d rst_n=%0d lost=%0d cnt=%0d",
                     s.name, s.cyc, st_a, rst_a, ll_a, rc_a, s.st, s.rst, s.ll, s.rc);
        end
    endfunction

    // Edge/snapshot monitor, sampling on the falling edge.
    logic  prev_rst = 1'b0;
    edge_t mon_e;
    snap_t mon_s;
    always @(negedge clk10) begin
        if (rif.sys_rst_n !== prev_rst) begin
            total++;
            if (edge_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_edge: sys_rst_n -> %0b at cyc=%0d, none expected", rif.sys_rst_n, cyc);
            end else begin
                mon_e = edge_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.val != int'(rif.sys_rst_n)) begin
                    bad++;
                    $display("FAIL rst_edge: got %0b at cyc=%0d, want %0d at cyc=%0d",
                             rif.sys_rst_n, cyc, mon_e.val, mon_e.cyc);
                end
            end
            prev_rst = rif.sys_rst_n;
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            mon_s = snap_q.pop_front();
            if (mon_s.cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: snapshot for cyc=%0d not sampled (now %0d)", mon_s.name, mon_s.cyc, cyc);
            end else begin
                check_snap(mon_s);
            end
        end
    end

    // Reset assertion must take effect without any clock edge.
    always @(negedge asyncrst_n) begin
        #1;
        while (async_q.size() > 0) check_snap(async_q.pop_front());
    end

    task automatic step(int n);
        repeat (n) @(negedge clk10);
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int    c;
        int    rc;
        snap_t a;

        asyncrst_n        = 1'b0;
        rif.mmcm_locked   = 1'b1;
        rif.sw_rst_req    = 1'b0;
        rif.lock_lost_clr = 1'b0;
        step(3);
        c = cyc;
        exp_snap(c + 1, 0, 0, 0, 0, "reset_state");
        step(2);

        // Power-up release with lock already high.
        c = cyc;
        asyncrst_n = 1'b1;
        exp_snap(c + 2,  0, 0, 0, 0, "pu_wait");
        exp_snap(c + 3,  1, 0, 0, 0, "pu_stable");
        exp_snap(c + 10, 1, 0, 0, 0, "pu_stable_end");
        exp_snap(c + 11, 2, 0, 0, 0, "pu_hold");
        exp_snap(c + 14, 2, 0, 0, 0, "pu_hold_end");
        exp_snap(c + 15, 3, 1, 0, 0, "pu_run");
        exp_edge(c + 15, 1);
        wait_until(c + 18);

        // Lock loss in RUN.
        c = cyc;
        rif.mmcm_locked = 1'b0;
        exp_snap(c + 2, 3, 1, 0, 0, "ll_still_run");
        exp_snap(c + 3, 0, 0, 1, 1, "ll_wait");
        exp_edge(c + 3, 0);
        wait_until(c + 5);

        // Relock, clear the flag, then a short drop while STABLE cnt=6.
        c = cyc;
        rif.mmcm_locked = 1'b1;
        exp_snap(c + 3, 1, 0, 1, 1, "relock_stable");
        exp_snap(c + 5, 1, 0, 0, 1, "clr_isolated");
        wait_until(c + 4);
        rif.lock_lost_clr = 1'b1;
        step(1);
        rif.lock_lost_clr = 1'b0;
        wait_until(c + 7);
        rif.mmcm_locked = 1'b0;
        exp_snap(c + 9,  1, 0, 0, 1, "glitch_stable");
        exp_snap(c + 10, 0, 0, 0, 1, "glitch_wait");
        wait_until(c + 12);
        rif.mmcm_locked = 1'b1;
        exp_snap(c + 14, 0, 0, 0, 1, "glitch_still_wait");
        exp_snap(c + 15, 1, 0, 0, 1, "glitch_restable");
        exp_snap(c + 26, 2, 0, 0, 1, "glitch_hold_end");
        exp_snap(c + 27, 3, 1, 0, 1, "glitch_run");
        exp_edge(c + 27, 1);
        wait_until(c + 30);

        // Clear coinciding with a new lock-loss set: set wins.
        c = cyc;
        rif.mmcm_locked = 1'b0;
        exp_edge(c + 3, 0);
        exp_snap(c + 3, 0, 0, 1, 2, "setclr_same");
        wait_until(c + 2);
        rif.lock_lost_clr = 1'b1;
        step(1);
        rif.lock_lost_clr = 1'b0;
        wait_until(c + 5);
        c = cyc;
        rif.mmcm_locked = 1'b1;
        exp_edge(c + 15, 1);
        exp_snap(c + 15, 3, 1, 1, 2, "relock2_run");
        wait_until(c + 17);
        c = cyc;
        exp_snap(c + 1, 3, 1, 0, 2, "clr_isolated2");
        rif.lock_lost_clr = 1'b1;
        step(1);
        rif.lock_lost_clr = 1'b0;
        step(3);

        // Software request held high for 50 cycles.
        c = cyc;
        rif.sw_rst_req = 1'b1;
        exp_snap(c + 2,  3, 1, 0, 2, "sw_pre");
        exp_snap(c + 3,  4, 0, 0, 3, "sw_rst");
        exp_snap(c + 5,  2, 0, 0, 3, "sw_hold");
        exp_snap(c + 9,  3, 1, 0, 3, "sw_run");
        exp_snap(c + 49, 3, 1, 0, 3, "sw_held_single");
        exp_edge(c + 3, 0);
        exp_edge(c + 9, 1);
        wait_until(c + 50);
        rif.sw_rst_req = 1'b0;
        wait_until(c + 55);

        // Second rise lands while HOLD and must be dropped.
        c = cyc;
        rif.sw_rst_req = 1'b1;
        exp_edge(c + 3, 0);
        exp_edge(c + 9, 1);
        exp_snap(c + 3,  4, 0, 0, 4, "sw2_rst");
        exp_snap(c + 12, 3, 1, 0, 4, "sw2_rise_ignored");
        wait_until(c + 3);
        rif.sw_rst_req = 1'b0;
        wait_until(c + 5);
        rif.sw_rst_req = 1'b1;
        wait_until(c + 20);
        rif.sw_rst_req = 1'b0;
        wait_until(c + 25);

        // Repeated lock losses drive the counter into saturation.
        rc = 4;
        for (int i = 0; i < 256; i++) begin
            c = cyc;
            rif.mmcm_locked = 1'b0;
            rc = (rc < 255) ? rc + 1 : 255;
            exp_edge(c + 3, 0);
            exp_snap(c + 3, 0, 0, 1, rc, "sat_step");
            wait_until(c + 3);
            rif.mmcm_locked = 1'b1;
            exp_edge(c + 18, 1);
            wait_until(c + 19);
        end
        c = cyc;
        exp_snap(c + 1, 3, 1, 1, 255, "sat_final");
        step(2);

        // Asynchronous reset in the middle of HOLD.
        c = cyc;
        rif.sw_rst_req = 1'b1;
        exp_edge(c + 3, 0);
        exp_snap(c + 3, 4, 0, 1, 255, "pre_arst_swrst");
        exp_snap(c + 5, 2, 0, 1, 255, "pre_arst_hold");
        wait_until(c + 6);
        a.cyc = c + 6; a.st = 0; a.rst = 0; a.ll = 0; a.rc = 0; a.name = "arst_immediate";
        async_q.push_back(a);
        #2 asyncrst_n = 1'b0;
        rif.sw_rst_req = 1'b0;
        step(3);
        c = cyc;
        asyncrst_n = 1'b1;
        exp_snap(c + 3,  1, 0, 0, 0, "rearst_stable");
        exp_snap(c + 15, 3, 1, 0, 0, "rearst_run");
        exp_edge(c + 15, 1);
        wait_until(c + 20);

        step(2);
        while (edge_q.size() > 0) begin
            mon_e = edge_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_edge: expected sys_rst_n=%0d at cyc=%0d never seen", mon_e.val, mon_e.cyc);
        end
        while (snap_q.size() > 0) begin
            mon_s = snap_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: snapshot for cyc=%0d never sampled", mon_s.name, mon_s.cyc);
        end
        while (async_q.size() > 0) begin
            mon_s = async_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: async reset check never performed", mon_s.name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
